// File: rtl/dma_burst_sequencer_if.sv
// Descriptor, burst-request and completion signals of dma_burst_sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface dma_burst_sequencer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SRC_W  = 32,
  parameter int unsigned DST_W  = 18,
  parameter int unsigned LEN_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       desc_valid;
  logic [NUM_CH-1:0]       desc_ready;
  logic [NUM_CH*SRC_W-1:0] desc_src;
  logic [NUM_CH*DST_W-1:0] desc_dst;
  logic [NUM_CH*LEN_W-1:0] desc_len;
  logic                    req_valid;
  logic                    req_ready;
  logic [SRC_W-1:0]        req_src;
  logic [DST_W-1:0]        req_dst;
  logic [8:0]              req_len;
  logic [CH_W-1:0]         req_ch;
  logic                    burst_done;
  logic                    cmpl_valid;
  logic [CH_W-1:0]         cmpl_ch;
  logic                    busy;

  modport master (
    output desc_valid, desc_src, desc_dst, desc_len, req_ready, burst_done,
    input  desc_ready, req_valid, req_src, req_dst, req_len, req_ch,
           cmpl_valid, cmpl_ch, busy
  );

  modport slave (
    input  desc_valid, desc_src, desc_dst, desc_len, req_ready, burst_done,
    output desc_ready, req_valid, req_src, req_dst, req_len, req_ch,
           cmpl_valid, cmpl_ch, busy
  );
endinterface

// File: rtl/dma_burst_sequencer.sv
// Round-robin descriptor arbiter that splits each descriptor into bursts of at most MAX_BURST words.
// Define DMA_BOUNDARY_SPLIT_EN to also stop bursts at 4 KiB source boundaries.
module dma_burst_sequencer #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned SRC_W     = 32,
  parameter int unsigned DST_W     = 18,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_BURST = 64
) (
  input logic                 clk,
  input logic                 rst,
  dma_burst_sequencer_if.slave dma
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BL_W = 9;
  localparam int unsigned CW   = (LEN_W > 12) ? LEN_W : 12;

  typedef enum logic [2:0] {IDLE, ARB, SPLIT, ISSUE, WAIT_DONE, CMPL} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0] desc_ready_q, desc_ready_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [BL_W-1:0]   req_len_q, req_len_d;
  logic              req_valid_q, req_valid_d;
  logic              cmpl_valid_q, cmpl_valid_d;
  logic [CH_W-1:0]   cmpl_ch_q, cmpl_ch_d;
  logic              busy_q, busy_d;

  logic              arb_any_c;
  logic [CH_W-1:0]   arb_grant_c;
  logic              sel_valid_c;
  logic [SRC_W-1:0]  sel_src_c;
  logic [DST_W-1:0]  sel_dst_c;
  logic [LEN_W-1:0]  sel_len_c;
  logic [BL_W-1:0]   blen_c;

  // Round-robin pick: lowest valid channel at or above rr_q, else lowest valid overall.
  always_comb begin
    logic            lo_f, hi_f;
    logic [CH_W-1:0] lo, hi;
    lo_f = 1'b0;
    hi_f = 1'b0;
    lo   = '0;
    hi   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (dma.desc_valid[i]) begin
        if (!lo_f) begin
          lo   = CH_W'(i);
          lo_f = 1'b1;
        end
        if (!hi_f && (i >= 32'(rr_q))) begin
          hi   = CH_W'(i);
          hi_f = 1'b1;
        end
      end
    end
    arb_any_c   = lo_f;
    arb_grant_c = hi_f ? hi : lo;
  end

  // Descriptor slice of the granted channel.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_src_c   = '0;
    sel_dst_c   = '0;
    sel_len_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_q) begin
        sel_valid_c = dma.desc_valid[i];
        sel_src_c   = dma.desc_src[i*SRC_W +: SRC_W];
        sel_dst_c   = dma.desc_dst[i*DST_W +: DST_W];
        sel_len_c   = dma.desc_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Next burst length from the remaining words and the active limits.
  always_comb begin
    logic [CW-1:0] blen_w;
`ifdef DMA_BOUNDARY_SPLIT_EN
    logic [CW-1:0] bnd_w;
`endif
    blen_w = CW'(MAX_BURST);
    if (CW'(remain_q) < blen_w) blen_w = CW'(remain_q);
`ifdef DMA_BOUNDARY_SPLIT_EN
    bnd_w = CW'(11'd1024 - 11'(src_q[11:2]));
    if (bnd_w < blen_w) blen_w = bnd_w;
`endif
    blen_c = BL_W'(blen_w);
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    desc_ready_d = '0;
    src_d        = src_q;
    dst_d        = dst_q;
    remain_d     = remain_q;
    req_len_d    = req_len_q;
    req_valid_d  = 1'b0;
    cmpl_valid_d = 1'b0;
    cmpl_ch_d    = cmpl_ch_q;
    busy_d       = 1'b0;

    case (state_q)
      IDLE:  state_d = arb_any_c ? ARB : IDLE;
      ARB: begin
        // A descriptor withdrawn during its ready cycle is not taken.
        if (sel_valid_c) begin
          src_d    = sel_src_c;
          dst_d    = sel_dst_c;
          remain_d = sel_len_c;
          state_d  = (sel_len_c == '0) ? CMPL : SPLIT;
        end else begin
          state_d = IDLE;
        end
      end
      SPLIT: begin
        req_len_d = blen_c;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (req_valid_q && dma.req_ready) begin
          remain_d = remain_q - LEN_W'(req_len_q);
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (dma.burst_done) begin
          src_d   = src_q + SRC_W'({req_len_q, 2'b00});
          dst_d   = dst_q + DST_W'({req_len_q, 2'b00});
          state_d = (remain_q != '0) ? SPLIT : CMPL;
        end
      end
      CMPL:    state_d = arb_any_c ? ARB : IDLE;
      default: state_d = IDLE;
    endcase

    // Grant is decided on entry to ARB so desc_ready is registered.
    if (state_d == ARB) begin
      grant_d      = arb_grant_c;
      rr_d         = (arb_grant_c == CH_W'(NUM_CH - 1)) ? '0 : arb_grant_c + CH_W'(1);
      desc_ready_d = NUM_CH'(1) << arb_grant_c;
    end
    req_valid_d  = (state_d == ISSUE);
    cmpl_valid_d = (state_d == CMPL);
    if (state_d == CMPL) cmpl_ch_d = grant_q;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      grant_q      <= '0;
      desc_ready_q <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      req_len_q    <= '0;
      req_valid_q  <= 1'b0;
      cmpl_valid_q <= 1'b0;
      cmpl_ch_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      desc_ready_q <= desc_ready_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remain_q     <= remain_d;
      req_len_q    <= req_len_d;
      req_valid_q  <= req_valid_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_ch_q    <= cmpl_ch_d;
      busy_q       <= busy_d;
    end
  end

  assign dma.desc_ready = desc_ready_q;
  assign dma.req_valid  = req_valid_q;
  assign dma.req_src    = src_q;
  assign dma.req_dst    = dst_q;
  assign dma.req_len    = req_len_q;
  assign dma.req_ch     = grant_q;
  assign dma.cmpl_valid = cmpl_valid_q;
  assign dma.cmpl_ch    = cmpl_ch_q;
  assign dma.busy       = busy_q;
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Directed self-checking bench for dma_burst_sequencer; follows DMA_BOUNDARY_SPLIT_EN if defined.
module tb_dma_burst_sequencer;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned SRC_W     = 32;
  localparam int unsigned DST_W     = 18;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MAX_BURST = 64;
  localparam int          BOUND     = 40;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dma_burst_sequencer_if #(.NUM_CH(NUM_CH), .SRC_W(SRC_W), .DST_W(DST_W), .LEN_W(LEN_W)) dif ();

  dma_burst_sequencer #(
    .NUM_CH(NUM_CH), .SRC_W(SRC_W), .DST_W(DST_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dma(dif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int ch, input logic [31:0] src, input logic [17:0] dst,
                          input logic [15:0] len);
    dif.desc_src[ch*SRC_W +: SRC_W] = src;
    dif.desc_dst[ch*DST_W +: DST_W] = dst;
    dif.desc_len[ch*LEN_W +: LEN_W] = len;
  endtask

  // Offer one descriptor, confirm its one-cycle desc_ready, then withdraw after the handshake edge.
  task automatic offer(input string tag, input int ch, input logic [1:0] exp_ready);
    dif.desc_valid[ch] = 1'b1;
    step();
    check({tag, "_ready"}, 64'(dif.desc_ready), 64'(exp_ready));
    step();
    dif.desc_valid[ch] = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (dif.req_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_req_seen"}, 64'(got), 64'(1));
  endtask

  task automatic do_burst(input string tag, input logic [31:0] src, input logic [17:0] dst,
                          input logic [8:0] len, input logic ch);
    wait_req(tag);
    check({tag, "_src"}, 64'(dif.req_src), 64'(src));
    check({tag, "_dst"}, 64'(dif.req_dst), 64'(dst));
    check({tag, "_len"}, 64'(dif.req_len), 64'(len));
    check({tag, "_ch"},  64'(dif.req_ch),  64'(ch));
    dif.req_ready = 1'b1;
    step();
    dif.req_ready = 1'b0;
    check({tag, "_req_drop"}, 64'(dif.req_valid), 64'(0));
    dif.burst_done = 1'b1;
    step();
    dif.burst_done = 1'b0;
    check({tag, "_gap"}, 64'(dif.req_valid), 64'(0));
  endtask

  task automatic wait_cmpl(input string tag, input logic ch);
    logic got = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (dif.cmpl_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_cmpl_seen"}, 64'(got), 64'(1));
    check({tag, "_cmpl_ch"}, 64'(dif.cmpl_ch), 64'(ch));
    step();
    check({tag, "_cmpl_pulse"}, 64'(dif.cmpl_valid), 64'(0));
  endtask

  initial begin
    rst            = 1'b1;
    dif.desc_valid = '0;
    dif.desc_src   = '0;
    dif.desc_dst   = '0;
    dif.desc_len   = '0;
    dif.req_ready  = 1'b0;
    dif.burst_done = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_busy",   64'(dif.busy),       64'(0));
    check("rst_rvalid", 64'(dif.req_valid),  64'(0));
    check("rst_dready", 64'(dif.desc_ready), 64'(0));
    check("rst_cvalid", 64'(dif.cmpl_valid), 64'(0));
    check("rst_rlen",   64'(dif.req_len),    64'(0));
    check("rst_cch",    64'(dif.cmpl_ch),    64'(0));
    rst = 1'b0;
    step();

    // 150 words at 0x1000 -> 64/64/22
    set_desc(0, 32'h1000, 18'h0, 16'd150);
    offer("split", 0, 2'b01);
    check("split_busy", 64'(dif.busy), 64'(1));
    do_burst("split_b0", 32'h1000, 18'h000, 9'd64, 1'b0);
    do_burst("split_b1", 32'h1100, 18'h100, 9'd64, 1'b0);
    do_burst("split_b2", 32'h1200, 18'h200, 9'd22, 1'b0);
    wait_cmpl("split", 1'b0);

    // Round-robin after a fresh reset: ch0, ch1, then re-offered ch0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_desc(0, 32'h2000, 18'h100, 16'd1);
    set_desc(1, 32'h3000, 18'h200, 16'd2);
    dif.desc_valid = 2'b11;
    step();
    check("rr_first_ready", 64'(dif.desc_ready), 64'(2'b01));
    step();
    dif.desc_valid[0] = 1'b0;
    // New ch0 contents while ch0's old descriptor is held must not disturb it
    set_desc(0, 32'h5000, 18'h300, 16'd1);
    dif.desc_valid[0] = 1'b1;
    do_burst("rr_ch0", 32'h2000, 18'h100, 9'd1, 1'b0);
    wait_cmpl("rr_ch0", 1'b0);
    check("rr_second_ready", 64'(dif.desc_ready), 64'(2'b10));
    step();
    dif.desc_valid[1] = 1'b0;
    do_burst("rr_ch1", 32'h3000, 18'h200, 9'd2, 1'b1);
    wait_cmpl("rr_ch1", 1'b1);
    check("rr_third_ready", 64'(dif.desc_ready), 64'(2'b01));
    step();
    dif.desc_valid[0] = 1'b0;
    do_burst("rr_ch0b", 32'h5000, 18'h300, 9'd1, 1'b0);
    wait_cmpl("rr_ch0b", 1'b0);

    // Zero length on ch1: cmpl two cycles after desc_valid is presented, no request
    step();
    set_desc(1, 32'h7000, 18'h0, 16'd0);
    offer("zero", 1, 2'b10);
    check("zero_cmpl", 64'(dif.cmpl_valid), 64'(1));
    check("zero_cch",  64'(dif.cmpl_ch),    64'(1));
    check("zero_noreq", 64'(dif.req_valid), 64'(0));
    step();
    check("zero_pulse", 64'(dif.cmpl_valid), 64'(0));
    check("zero_idle",  64'(dif.busy),       64'(0));

    // Backpressure: fields stable for 5 stalled cycles, exactly one handshake
    set_desc(0, 32'h4000, 18'h80, 16'd10);
    offer("stall", 0, 2'b01);
    wait_req("stall");
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(dif.req_valid), 64'(1));
      check("stall_src",   64'(dif.req_src),   64'(32'h4000));
      check("stall_dst",   64'(dif.req_dst),   64'(18'h80));
      check("stall_len",   64'(dif.req_len),   64'(10));
      step();
    end
    dif.req_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check("stall_single", 64'(dif.req_valid), 64'(0));
      step();
    end
    dif.req_ready = 1'b0;
    dif.burst_done = 1'b1;
    step();
    dif.burst_done = 1'b0;
    wait_cmpl("stall", 1'b0);

    // Stray burst_done while idle is ignored
    step();
    dif.burst_done = 1'b1;
    step();
    dif.burst_done = 1'b0;
    step();
    check("stray_busy", 64'(dif.busy), 64'(0));
    check("stray_req",  64'(dif.req_valid) | 64'(dif.cmpl_valid), 64'(0));

    // 20 words at 0x0FF0
    set_desc(0, 32'h0FF0, 18'h40, 16'd20);
    offer("bnd", 0, 2'b01);
`ifdef DMA_BOUNDARY_SPLIT_EN
    do_burst("bnd_b0", 32'h0FF0, 18'h40, 9'd4,  1'b0);
    do_burst("bnd_b1", 32'h1000, 18'h50, 9'd16, 1'b0);
`else
    do_burst("bnd_b0", 32'h0FF0, 18'h40, 9'd20, 1'b0);
`endif
    wait_cmpl("bnd", 1'b0);

    // Reset while waiting for burst_done abandons the descriptor
    set_desc(0, 32'h6000, 18'h0, 16'd100);
    offer("abort", 0, 2'b01);
    wait_req("abort");
    dif.req_ready = 1'b1;
    step();
    dif.req_ready = 1'b0;
    check("abort_in_wait", 64'(dif.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("abort_busy",   64'(dif.busy),       64'(0));
    check("abort_rvalid", 64'(dif.req_valid),  64'(0));
    check("abort_dready", 64'(dif.desc_ready), 64'(0));
    check("abort_cvalid", 64'(dif.cmpl_valid), 64'(0));
    check("abort_rsrc",   64'(dif.req_src),    64'(0));
    check("abort_rlen",   64'(dif.req_len),    64'(0));
    #2;
    rst = 1'b0;
    dif.burst_done = 1'b1;
    step();
    dif.burst_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("abort_quiet", 64'({dif.busy, dif.req_valid, dif.cmpl_valid}), 64'(0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
